// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder
// Brief    : Measures period/high time of an external PWM pin, quantises the
//            duty to a 3-bit speed code and flags a stuck line.
// Revision : 1.0
// ============================================================================
module pwm_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [2:0]       duty_code,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam int               c_wide_w  = CNT_W + 3;
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, pwm_s_q, pwm_d_q;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [2:0]       duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             level_q, level_d;

    logic             w_rise;
    logic [2:0]       w_duty;
    logic [c_wide_w-1:0] w_hi8;

    assign w_rise = pwm_s_q & ~pwm_d_q;
    assign w_hi8  = {hi_acc_q, 3'b000};

    // Duty = number of thresholds k/8 that the high fraction reaches; no divider.
    always_comb begin
        w_duty = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_hi8 >= (c_wide_w'(k) * {3'b000, run_cnt_q})) begin
                w_duty = w_duty + 3'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        hi_acc_d  = hi_acc_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;
        level_d   = level_q;
        case (state_q)
            IDLE: begin
                run_cnt_d = '0;
                hi_acc_d  = '0;
                if (ena && w_rise) begin
                    run_cnt_d = CNT_W'(1);
                    hi_acc_d  = CNT_W'(1);
                    state_d   = MEAS;
                end
            end
            MEAS: begin
                if (!ena) begin
                    run_cnt_d = '0;
                    hi_acc_d  = '0;
                    state_d   = IDLE;
                end else if (w_rise) begin
                    // A rise on the timeout cycle still counts as a measurement.
                    period_d  = run_cnt_q;
                    high_d    = hi_acc_q;
                    duty_d    = w_duty;
                    valid_d   = 1'b1;
                    stuck_d   = 1'b0;
                    run_cnt_d = CNT_W'(1);
                    hi_acc_d  = CNT_W'(1);
                end else if (run_cnt_q == c_timeout) begin
                    stuck_d   = 1'b1;
                    level_d   = pwm_s_q;
                    duty_d    = pwm_s_q ? 3'd7 : 3'd0;
                    period_d  = '0;
                    high_d    = '0;
                    run_cnt_d = '0;
                    hi_acc_d  = '0;
                    state_d   = IDLE;
                end else begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                    hi_acc_d  = hi_acc_q + {{(CNT_W-1){1'b0}}, pwm_s_q};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            pwm_s_q   <= 1'b0;
            pwm_d_q   <= 1'b0;
            state_q   <= IDLE;
            run_cnt_q <= '0;
            hi_acc_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= 3'd0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            sync1_q   <= pwm_in;
            pwm_s_q   <= sync1_q;
            pwm_d_q   <= pwm_s_q;
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            hi_acc_q  <= hi_acc_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
            level_q   <= level_d;
        end
    end

    assign period_cnt  = period_q;
    assign high_cnt    = high_q;
    assign duty_code   = duty_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = level_q;

endmodule
`default_nettype wire
